// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI transfer sequencer: register map, CTRL bits,
// FSM state encoding, the Wishbone request bundle and the length-to-mask helper.
package spi_xfer_pkg;

    localparam logic [2:0] ADR_RX0     = 3'd0;
    localparam logic [2:0] ADR_TX0     = 3'd0;
    localparam logic [2:0] ADR_CTRL    = 3'd4;
    localparam logic [2:0] ADR_DIVIDER = 3'd5;
    localparam logic [2:0] ADR_SS      = 3'd6;

    localparam int CTRL_GO_BSY = 8;
    localparam int CTRL_RX_NEG = 9;
    localparam int CTRL_TX_NEG = 10;
    localparam int CTRL_LSB    = 11;
    localparam int CTRL_IE     = 12;
    localparam int CTRL_ASS    = 13;

    typedef enum logic [3:0] {
        ST_INIT_DIV,
        ST_INIT_SS,
        ST_IDLE,
        ST_W_TX,
        ST_W_GO,
        ST_POLL,
        ST_GAP,
        ST_R_RX,
        ST_RESP
    } t_xfer_state;

    typedef struct packed {
        logic        we;
        logic [2:0]  adr;
        logic [31:0] dat;
    } wb_req_t;

    // len is already normalised to 1..32; 32 (bit 5 set) keeps every bit.
    function automatic logic [31:0] len_mask(input logic [5:0] len);
        logic [31:0] m;
        if (len == 6'd0 || len[5])
            m = '1;
        else
            m = (32'h1 << len) - 32'h1;
        return m;
    endfunction

endpackage

// File: rtl/wb_single_access.sv
// One Wishbone single read or write, with an ack timeout.
// Latency: cyc one cycle after start, done one cycle after ack/err/timeout.
// Backpressure: start is ignored while an access is outstanding.
module wb_single_access
    import spi_xfer_pkg::*;
#(
    parameter int G_ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  wb_req_t     req_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [2:0]  wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int CW = $clog2(G_ACK_TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign wb_sel_o = 4'hF;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wait_cnt <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            done_o <= 1'b0;
            if (!wb_cyc_o) begin
                if (start_i) begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= req_i.we;
                    wb_adr_o <= req_i.adr;
                    wb_dat_o <= req_i.dat;
                    wait_cnt <= '0;
                end
            end else if (wb_ack_i || wb_err_i || wait_cnt == CW'(G_ACK_TIMEOUT - 1)) begin
                // Error wins over a simultaneous ack; no ack at all means timeout.
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                done_o   <= 1'b1;
                err_o    <= wb_err_i || !wb_ack_i;
                rdata_o  <= wb_dat_i;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_master.sv
// Sequences Wishbone accesses to an SPI core: init DIVIDER/SS, then TX0, CTRL+GO, poll, RX0 per command.
// Latency: at least four bus accesses plus SPI shift time from command accept to response.
// Backpressure: one command in flight; cmd_ready_o low until the response is taken by rsp_ready_i.
module spi_xfer_master
    import spi_xfer_pkg::*;
#(
    parameter logic [15:0] G_DIVIDER     = 16'd4,
    parameter logic [13:0] G_CTRL_FLAGS  = 14'h2400,
    parameter int          G_POLL_GAP    = 8,
    parameter int          G_ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_data_i,
    input  logic [5:0]  cmd_len_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [2:0]  wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int GW = $clog2(G_POLL_GAP + 1);

    t_xfer_state   state;
    logic          init_done;
    logic          acc_pend;
    logic          acc_start;
    wb_req_t       acc_req;
    wb_req_t       nxt_req;
    logic          acc_done;
    logic          acc_err;
    logic [31:0]   acc_rdata;
    logic [31:0]   cmd_dat;
    logic [5:0]    cmd_len;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   ctrl_word;

    assign ctrl_word = {18'h0, G_CTRL_FLAGS} | (32'h1 << CTRL_GO_BSY) | {26'h0, cmd_len};

    always_comb begin
        nxt_req = '0;
        case (state)
            ST_INIT_DIV: nxt_req = '{we: 1'b1, adr: ADR_DIVIDER, dat: {16'h0, G_DIVIDER}};
            ST_INIT_SS:  nxt_req = '{we: 1'b1, adr: ADR_SS,      dat: 32'h1};
            ST_W_TX:     nxt_req = '{we: 1'b1, adr: ADR_TX0,     dat: cmd_dat};
            ST_W_GO:     nxt_req = '{we: 1'b1, adr: ADR_CTRL,    dat: ctrl_word};
            ST_POLL:     nxt_req = '{we: 1'b0, adr: ADR_CTRL,    dat: 32'h0};
            ST_R_RX:     nxt_req = '{we: 1'b0, adr: ADR_RX0,     dat: 32'h0};
            default:     nxt_req = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_INIT_DIV;
            init_done   <= 1'b0;
            acc_pend    <= 1'b0;
            acc_start   <= 1'b0;
            acc_req     <= '0;
            cmd_dat     <= '0;
            cmd_len     <= '0;
            gap_cnt     <= '0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            acc_start <= 1'b0;
            case (state)
                ST_INIT_DIV, ST_INIT_SS, ST_W_TX, ST_W_GO, ST_POLL, ST_R_RX: begin
                    if (!acc_pend) begin
                        acc_pend  <= 1'b1;
                        acc_start <= 1'b1;
                        acc_req   <= nxt_req;
                    end else if (acc_done) begin
                        acc_pend <= 1'b0;
                        if (acc_err) begin
                            // A failed access may have left the core half-programmed.
                            init_done <= 1'b0;
                            if (state == ST_INIT_DIV || state == ST_INIT_SS) begin
                                state <= ST_INIT_DIV;
                            end else begin
                                rsp_valid_o <= 1'b1;
                                rsp_err_o   <= 1'b1;
                                rsp_data_o  <= '0;
                                state       <= ST_RESP;
                            end
                        end else begin
                            case (state)
                                ST_INIT_DIV: state <= ST_INIT_SS;
                                ST_INIT_SS: begin
                                    init_done   <= 1'b1;
                                    cmd_ready_o <= 1'b1;
                                    state       <= ST_IDLE;
                                end
                                ST_W_TX: state <= ST_W_GO;
                                ST_W_GO: state <= ST_POLL;
                                ST_POLL: begin
                                    if (acc_rdata[CTRL_GO_BSY]) begin
                                        gap_cnt <= GW'(G_POLL_GAP - 1);
                                        state   <= ST_GAP;
                                    end else begin
                                        state <= ST_R_RX;
                                    end
                                end
                                default: begin
                                    rsp_valid_o <= 1'b1;
                                    rsp_err_o   <= 1'b0;
                                    rsp_data_o  <= acc_rdata & len_mask(cmd_len);
                                    state       <= ST_RESP;
                                end
                            endcase
                        end
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        cmd_dat     <= cmd_data_i;
                        cmd_len     <= (cmd_len_i == 6'd0 || cmd_len_i > 6'd32) ? 6'd32 : cmd_len_i;
                        state       <= ST_W_TX;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0)
                        state <= ST_POLL;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= '0;
                        if (init_done) begin
                            cmd_ready_o <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_INIT_DIV;
                        end
                    end
                end
                default: state <= ST_INIT_DIV;
            endcase
        end
    end

    wb_single_access #(
        .G_ACK_TIMEOUT(G_ACK_TIMEOUT)
    ) u_acc (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (acc_start),
        .req_i    (acc_req),
        .done_o   (acc_done),
        .err_o    (acc_err),
        .rdata_o  (acc_rdata),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

endmodule
